// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - GPIO controller register map, reset constants and bus FSM states
package gpio_pkg;

  localparam logic [7:0] GPIO_OUT_OFS   = 8'h00;
  localparam logic [7:0] GPIO_OENB_OFS  = 8'h04;
  localparam logic [7:0] GPIO_IN_OFS    = 8'h08;
  localparam logic [7:0] GPIO_PUB_OFS   = 8'h0C;
  localparam logic [7:0] GPIO_PDB_OFS   = 8'h10;
  localparam logic [7:0] GPIO_RISE_OFS  = 8'h14;
  localparam logic [7:0] GPIO_FALL_OFS  = 8'h18;
  localparam logic [7:0] GPIO_STAT_OFS  = 8'h1C;
  localparam logic [7:0] GPIO_DBDIV_OFS = 8'h20;

  localparam logic [31:0] GPIO_OUT_RST  = 32'h0000_0000;
  localparam logic [31:0] GPIO_OENB_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] GPIO_PUB_RST  = 32'hFFFF_FFFF;
  localparam logic [31:0] GPIO_PDB_RST  = 32'hFFFF_FFFF;

  typedef enum logic {
    BUS_IDLE,
    BUS_ACK
  } bus_state_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_db_filter.sv
// rtl/gpio_db_filter.sv - per-pin 3-sample debounce filter, built only with GPIO_DEBOUNCE_EN
`ifdef GPIO_DEBOUNCE_EN
module gpio_db_filter (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic tick_i,
  input  logic in_i,
  output logic val_o
);

  logic s1_q, s2_q, val_q;

  // The current tick sample plus the two previous ones must all agree.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      val_q <= 1'b0;
    end else if (tick_i) begin
      s1_q <= in_i;
      s2_q <= s1_q;
      if ((in_i == s1_q) && (s1_q == s2_q)) begin
        val_q <= in_i;
      end
    end
  end

  assign val_o = val_q;

endmodule
`endif

// File: rtl/gpio_pad_ctrl.sv
// rtl/gpio_pad_ctrl.sv - GPIO pad controller: registers, input sync, edge IRQs, bus FSM
// Optional debounce prescaler/filter built when GPIO_DEBOUNCE_EN is defined.
module gpio_pad_ctrl
  import gpio_pkg::*;
#(
  parameter int GPIO_NUM    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                mem_valid_i,
  output logic                mem_ready_o,
  input  logic [7:0]          mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic [3:0]          mem_wstrb_i,
  output logic [31:0]         mem_rdata_o,
  output logic [GPIO_NUM-1:0] gpio_out_o,
  output logic [GPIO_NUM-1:0] gpio_outenb_o,
  output logic [GPIO_NUM-1:0] gpio_pullupb_o,
  output logic [GPIO_NUM-1:0] gpio_pulldownb_o,
  input  logic [GPIO_NUM-1:0] gpio_in_i,
  output logic                irq_o
);

  bus_state_e          state_q;
  logic                mem_ready_q;
  logic [31:0]         mem_rdata_q;
  logic [GPIO_NUM-1:0] out_q, oenb_q, pub_q, pdb_q, rise_en_q, fall_en_q;
  logic [GPIO_NUM-1:0] stat_q, stat_d, stat_clr;
  logic                irq_q;
  logic [GPIO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_NUM-1:0] in_sync, in_val, in_prev_q, edge_set;
  logic [7:0]          addr_w;
  logic                acc_en, wr_en;
  logic [31:0]         wmask32, rd_val;
  logic [GPIO_NUM-1:0] wmask, wdata;
  logic                unused_bits;

  assign addr_w      = {mem_addr_i[7:2], 2'b00};
  assign acc_en      = (state_q == BUS_IDLE) && mem_valid_i;
  assign wr_en       = acc_en && (mem_wstrb_i != 4'b0000);
  assign wmask32     = strb_mask(mem_wstrb_i);
  assign wmask       = wmask32[GPIO_NUM-1:0];
  assign wdata       = mem_wdata_i[GPIO_NUM-1:0];
  assign unused_bits = ^{mem_addr_i[1:0], mem_wdata_i, wmask32};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_div_q, db_cnt_q;
  logic [GPIO_NUM-1:0] db_val;
  logic                db_tick;

  assign db_tick = (db_cnt_q == db_div_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      db_div_q <= '0;
      db_cnt_q <= '0;
    end else if (wr_en && (addr_w == GPIO_DBDIV_OFS)) begin
      db_div_q <= (db_div_q & ~wmask32[DB_CNT_W-1:0]) | (mem_wdata_i[DB_CNT_W-1:0] & wmask32[DB_CNT_W-1:0]);
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_tick ? '0 : db_cnt_q + DB_CNT_W'(1);
    end
  end

  for (genvar g = 0; g < GPIO_NUM; g++) begin : g_db
    gpio_db_filter u_db_filter (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .tick_i  (db_tick),
      .in_i    (in_sync[g]),
      .val_o   (db_val[g])
    );
  end

  // DB_DIV=0 is the bypass setting; the filters keep tracking so re-enabling is glitch-free.
  assign in_val = (db_div_q == '0) ? in_sync : db_val;
`else
  logic [DB_CNT_W-1:0] unused_db_div;
  assign unused_db_div = '0;
  assign in_val        = in_sync;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q     <= GPIO_OUT_RST[GPIO_NUM-1:0];
      oenb_q    <= GPIO_OENB_RST[GPIO_NUM-1:0];
      pub_q     <= GPIO_PUB_RST[GPIO_NUM-1:0];
      pdb_q     <= GPIO_PDB_RST[GPIO_NUM-1:0];
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (addr_w)
        GPIO_OUT_OFS:  out_q     <= (out_q & ~wmask) | (wdata & wmask);
        GPIO_OENB_OFS: oenb_q    <= (oenb_q & ~wmask) | (wdata & wmask);
        GPIO_PUB_OFS:  pub_q     <= (pub_q & ~wmask) | (wdata & wmask);
        GPIO_PDB_OFS:  pdb_q     <= (pdb_q & ~wmask) | (wdata & wmask);
        GPIO_RISE_OFS: rise_en_q <= (rise_en_q & ~wmask) | (wdata & wmask);
        GPIO_FALL_OFS: fall_en_q <= (fall_en_q & ~wmask) | (wdata & wmask);
        default: ;
      endcase
    end
  end

  // A new edge is ORed in after the W1C clear, so a same-cycle set wins.
  assign edge_set = (in_val & ~in_prev_q & rise_en_q) | (~in_val & in_prev_q & fall_en_q);
  assign stat_clr = (wr_en && (addr_w == GPIO_STAT_OFS)) ? (wdata & wmask) : '0;
  assign stat_d   = (stat_q & ~stat_clr) | edge_set;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_prev_q <= '0;
      stat_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      in_prev_q <= in_val;
      stat_q    <= stat_d;
      irq_q     <= |stat_q;
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr_w)
      GPIO_OUT_OFS:   rd_val = 32'(out_q);
      GPIO_OENB_OFS:  rd_val = 32'(oenb_q);
      GPIO_IN_OFS:    rd_val = 32'(in_val);
      GPIO_PUB_OFS:   rd_val = 32'(pub_q);
      GPIO_PDB_OFS:   rd_val = 32'(pdb_q);
      GPIO_RISE_OFS:  rd_val = 32'(rise_en_q);
      GPIO_FALL_OFS:  rd_val = 32'(fall_en_q);
      GPIO_STAT_OFS:  rd_val = 32'(stat_q);
`ifdef GPIO_DEBOUNCE_EN
      GPIO_DBDIV_OFS: rd_val = 32'(db_div_q);
`endif
      default:        rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= BUS_IDLE;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      case (state_q)
        BUS_IDLE: begin
          if (acc_en) begin
            state_q     <= BUS_ACK;
            mem_ready_q <= 1'b1;
            mem_rdata_q <= (mem_wstrb_i == 4'b0000) ? rd_val : '0;
          end
        end
        BUS_ACK: begin
          state_q     <= BUS_IDLE;
          mem_ready_q <= 1'b0;
          mem_rdata_q <= '0;
        end
      endcase
    end
  end

  assign mem_ready_o      = mem_ready_q;
  assign mem_rdata_o      = mem_rdata_q;
  assign gpio_out_o       = out_q;
  assign gpio_outenb_o    = oenb_q;
  assign gpio_pullupb_o   = pub_q;
  assign gpio_pulldownb_o = pdb_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb/tb_gpio_pad_ctrl.sv - directed self-checking bench for gpio_pad_ctrl
module tb_gpio_pad_ctrl;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, rd;
  logic [3:0]  mem_wstrb;
  logic [15:0] gpio_out, gpio_outenb, gpio_pullupb, gpio_pulldownb, gpio_in;
  logic        irq;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] rst_exp [9];

  gpio_pad_ctrl #(.GPIO_NUM(16), .SYNC_STAGES(2), .DB_CNT_W(16)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .mem_valid_i      (mem_valid),
    .mem_ready_o      (mem_ready),
    .mem_addr_i       (mem_addr),
    .mem_wdata_i      (mem_wdata),
    .mem_wstrb_i      (mem_wstrb),
    .mem_rdata_o      (mem_rdata),
    .gpio_out_o       (gpio_out),
    .gpio_outenb_o    (gpio_outenb),
    .gpio_pullupb_o   (gpio_pullupb),
    .gpio_pulldownb_o (gpio_pulldownb),
    .gpio_in_i        (gpio_in),
    .irq_o            (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts after one idle cycle so every access sees the FSM in IDLE.
  task automatic bus(input logic [7:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     output logic [31:0] rdo);
    int  cyc;
    bit  done;
    @(negedge clk);
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    mem_valid = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
      done = mem_ready;
    end
    rdo = mem_rdata;
    check("ready_latency", 32'(cyc), 32'd1);
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] dummy;
    bus(a, d, s, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 32'd0, 4'b0000, r);
    check(tag, r, exp);
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 32'd0;
    mem_wstrb = 4'b0000;
    gpio_in   = 16'h0000;
    rst_exp   = '{32'h0, 32'hFFFF, 32'h0, 32'hFFFF, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_out", 32'(gpio_out), 32'h0000);
    check("rst_outenb", 32'(gpio_outenb), 32'hFFFF);
    check("rst_pullupb", 32'(gpio_pullupb), 32'hFFFF);
    check("rst_pulldownb", 32'(gpio_pulldownb), 32'hFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) rd_chk($sformatf("rst_reg_%02h", i * 4), 8'(i * 4), rst_exp[i]);

    wr(GPIO_OUT_OFS, 32'h0000_A5A5, 4'b0001);
    rd_chk("out_byte0", GPIO_OUT_OFS, 32'h0000_00A5);
    check("gpio_out_byte0", 32'(gpio_out), 32'h00A5);
    wr(GPIO_OUT_OFS, 32'h1234_5678, 4'b1111);
    rd_chk("out_upper_masked", GPIO_OUT_OFS, 32'h0000_5678);
    wr(GPIO_OENB_OFS, 32'hFFFF_00F0, 4'b1111);
    rd_chk("oenb", GPIO_OENB_OFS, 32'h0000_00F0);
    check("gpio_outenb", 32'(gpio_outenb), 32'h00F0);
    wr(GPIO_PUB_OFS, 32'h0000_1200, 4'b0010);
    rd_chk("pub_byte1", GPIO_PUB_OFS, 32'h0000_12FF);
    check("gpio_pullupb", 32'(gpio_pullupb), 32'h12FF);

    wr(GPIO_RISE_OFS, 32'h0000_0001, 4'b1111);
    gpio_in[0] = 1'b1;
    bus(GPIO_IN_OFS, 32'd0, 4'b0000, rd);
    check("in_sync_latency", rd, 32'h0);
    @(negedge clk);
    check("irq_not_yet", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'd1);
    rd_chk("in_pin0", GPIO_IN_OFS, 32'h1);
    rd_chk("stat_rise0", GPIO_STAT_OFS, 32'h1);

    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_in[0] = 1'b1;
    @(negedge clk);
    wr(GPIO_STAT_OFS, 32'h1, 4'b1111);
    rd_chk("stat_set_wins", GPIO_STAT_OFS, 32'h1);
    check("irq_held", 32'(irq), 32'd1);
    wr(GPIO_STAT_OFS, 32'h1, 4'b1111);
    check("irq_before_fall", 32'(irq), 32'd1);
    @(negedge clk);
    check("irq_fall", 32'(irq), 32'd0);
    rd_chk("stat_cleared", GPIO_STAT_OFS, 32'h0);

    wr(GPIO_FALL_OFS, 32'h4, 4'b0001);
    gpio_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    gpio_in[2] = 1'b0;
    repeat (5) @(negedge clk);
    rd_chk("stat_fall2", GPIO_STAT_OFS, 32'h4);
    wr(GPIO_STAT_OFS, 32'h4, 4'b0001);
    rd_chk("stat_fall2_clr", GPIO_STAT_OFS, 32'h0);

    gpio_in[1] = 1'b1;
    repeat (5) @(negedge clk);
    wr(GPIO_RISE_OFS, 32'h3, 4'b0001);
    repeat (3) @(negedge clk);
    rd_chk("no_retro_set", GPIO_STAT_OFS, 32'h0);

    rd_chk("unmapped_read", 8'h3C, 32'h0);
    wr(8'h3C, 32'hFFFF_FFFF, 4'b1111);
    @(negedge clk);
    check("ready_once", 32'(mem_ready), 32'd0);
    rd_chk("unmapped_out", GPIO_OUT_OFS, 32'h5678);
    rd_chk("unmapped_oenb", GPIO_OENB_OFS, 32'h00F0);
    rd_chk("unmapped_pub", GPIO_PUB_OFS, 32'h12FF);

`ifdef GPIO_DEBOUNCE_EN
    wr(GPIO_RISE_OFS, 32'h8, 4'b0001);
    wr(GPIO_DBDIV_OFS, 32'h4, 4'b0001);
    rd_chk("dbdiv", GPIO_DBDIV_OFS, 32'h4);
    gpio_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (25) @(negedge clk);
    rd_chk("db_glitch_stat", GPIO_STAT_OFS, 32'h0);
    rd_chk("db_glitch_in", GPIO_IN_OFS, 32'h3);
    gpio_in[3] = 1'b1;
    repeat (25) @(negedge clk);
    rd_chk("db_stable_in", GPIO_IN_OFS, 32'hB);
    rd_chk("db_stable_stat", GPIO_STAT_OFS, 32'h8);
`else
    wr(GPIO_DBDIV_OFS, 32'h4, 4'b1111);
    rd_chk("dbdiv_absent", GPIO_DBDIV_OFS, 32'h0);
    rd_chk("in_pins01", GPIO_IN_OFS, 32'h3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
